// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word at a time from instruction memory,
// holds it until the core retires it, then computes the next PC.
module ifu #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PC_Sel,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] inst_count,
  output logic        fetch_err
);

  localparam int WaitW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    ERROR = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             started_q, started_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      count_q, count_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic [31:0]      pcPlus4;
  logic [31:0]      branchOffset;
  logic [31:0]      nextPc;
  logic [WaitW-1:0] waitInc;

  // Branch offsets are word counts, so they are sign-extended and scaled by 4.
  assign pcPlus4      = pc_q + 32'd4;
  assign branchOffset = {{14{imm16[15]}}, imm16, 2'b00};
  assign waitInc      = wait_q + WaitW'(1);

  always_comb begin
    nextPc = pcPlus4;
    case (PC_Sel)
      2'b01:   nextPc = pcPlus4 + branchOffset;
      2'b10:   nextPc = {pcPlus4[31:28], target26, 2'b00};
      default: nextPc = pcPlus4;
    endcase
  end

  // started_q keeps the request low until the first edge after reset release.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    pc_d      = pc_q;
    inst_d    = inst_q;
    count_d   = count_q;
    wait_d    = wait_q;
    case (state_q)
      FETCH: begin
        if (started_q) begin
          if (imem_ack) begin
            inst_d  = imem_rdata;
            state_d = HOLD;
            wait_d  = '0;
          end else if (ACK_TIMEOUT != 0) begin
            wait_d = waitInc;
            if (waitInc == WaitLimit) begin
              state_d = ERROR;
            end
          end
        end
      end
      HOLD: begin
        if (exec_done) begin
          pc_d    = {nextPc[31:2], 2'b00};
          count_d = count_q + 32'd1;
          wait_d  = '0;
          state_d = FETCH;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      inst_q    <= '0;
      count_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
    end
  end

  assign imem_req   = (state_q == FETCH) && started_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign op         = inst_q[31:26];
  assign func       = inst_q[5:0];
  assign inst_valid = (state_q == HOLD);
  assign pc         = pc_q;
  assign inst_count = count_q;
  assign fetch_err  = (state_q == ERROR);

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: fetch/retire sequencing, next-PC selection,
// wrap-around, reset abandonment and ack timeout.
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PC_Sel;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        exec_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] inst_count;
  logic        fetch_err;

  int testsRun;
  int testsFailed;

  ifu #(
    .RESET_PC   (32'h0000_3000),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PC_Sel    (PC_Sel),
    .imm16     (imm16),
    .target26  (target26),
    .exec_done (exec_done),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .op        (op),
    .func      (func),
    .inst_valid(inst_valid),
    .pc        (pc),
    .inst_count(inst_count),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] imm,
                               input logic [25:0] tgt);
    PC_Sel    = sel;
    imm16     = imm;
    target26  = tgt;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    PC_Sel    = 2'b00;
    imm16     = '0;
    target26  = '0;
  endtask

  task automatic fetchWord(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    PC_Sel      = 2'b00;
    imm16       = '0;
    target26    = '0;
    exec_done   = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;

    repeat (2) tick();
    checkOutput("rst_pc",    pc,                32'h0000_3000);
    checkOutput("rst_inst",  inst,              32'h0);
    checkOutput("rst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("rst_count", inst_count,        32'h0);
    checkOutput("rst_err",   {31'b0, fetch_err},  32'h0);
    checkOutput("rst_req",   {31'b0, imem_req},   32'h0);

    rst_n = 1'b1;
    tick();
    checkOutput("first_req",  {31'b0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr,       32'h0000_3000);

    repeat (2) tick();
    checkOutput("wait2_req", {31'b0, imem_req}, 32'h1);
    fetchWord(32'h2108_0001);
    checkOutput("f1_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("f1_inst",  inst,              32'h2108_0001);
    checkOutput("f1_op",    {26'b0, op},       32'h08);
    checkOutput("f1_func",  {26'b0, func},     32'h01);
    checkOutput("f1_req",   {31'b0, imem_req},   32'h0);
    checkOutput("f1_pc",    pc,                32'h0000_3000);

    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    checkOutput("hold_inst",  inst,              32'h2108_0001);
    checkOutput("hold_valid", {31'b0, inst_valid}, 32'h1);

    applyStimulus(2'b01, 16'hFFFF, 26'h0);
    checkOutput("br_back_pc",    pc,                32'h0000_3000);
    checkOutput("br_back_count", inst_count,        32'h1);
    checkOutput("br_back_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("br_back_req",   {31'b0, imem_req},   32'h1);

    fetchWord(32'h0000_0020);
    checkOutput("lat0_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("lat0_func",  {26'b0, func},     32'h20);

    applyStimulus(2'b00, 16'h0, 26'h0);
    checkOutput("seq_pc",    pc,         32'h0000_3004);
    checkOutput("seq_count", inst_count, 32'h2);

    fetchWord(32'h0800_0C10);
    applyStimulus(2'b10, 16'h0, 26'h000_0C10);
    checkOutput("jmp_pc",    pc,         32'h0000_3040);
    checkOutput("jmp_count", inst_count, 32'h3);

    fetchWord(32'h0000_0000);
    applyStimulus(2'b11, 16'h7FFF, 26'h3FF_FFFF);
    checkOutput("sel11_pc", pc, 32'h0000_3044);

    fetchWord(32'h1000_F3ED);
    applyStimulus(2'b01, 16'hF3ED, 26'h0);
    checkOutput("br_wrap_pc",   pc,        32'hFFFF_FFFC);
    checkOutput("br_wrap_addr", imem_addr, 32'hFFFF_FFFC);

    fetchWord(32'h0000_0000);
    applyStimulus(2'b00, 16'h0, 26'h0);
    checkOutput("seq_wrap_pc",    pc,         32'h0000_0000);
    checkOutput("seq_wrap_count", inst_count, 32'h6);

    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    checkOutput("fetch_ign_pc",    pc,         32'h0000_0000);
    checkOutput("fetch_ign_count", inst_count, 32'h6);

    fetchWord(32'h1234_5678);
    checkOutput("pre_rst_valid", {31'b0, inst_valid}, 32'h1);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("async_count", inst_count,        32'h0);
    checkOutput("async_pc",    pc,                32'h0000_3000);
    checkOutput("async_req",   {31'b0, imem_req},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("refetch_req",  {31'b0, imem_req}, 32'h1);
    checkOutput("refetch_addr", imem_addr,       32'h0000_3000);

    repeat (15) tick();
    checkOutput("to15_err", {31'b0, fetch_err}, 32'h0);
    checkOutput("to15_req", {31'b0, imem_req},  32'h1);
    tick();
    checkOutput("to16_err",   {31'b0, fetch_err},  32'h1);
    checkOutput("to16_req",   {31'b0, imem_req},   32'h0);
    checkOutput("to16_valid", {31'b0, inst_valid}, 32'h0);

    fetchWord(32'hCAFE_F00D);
    checkOutput("err_ack_err",   {31'b0, fetch_err},  32'h1);
    checkOutput("err_ack_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("err_ack_req",   {31'b0, imem_req},   32'h0);
    checkOutput("err_ack_count", inst_count,        32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
